store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer sitting directly upstream of the 256-word data memory in the MEM stage. Stores from the pipeline are accepted into a small FIFO and retired to the memory write port in cycles when the pipeline is not issuing a load. Loads are checked against the buffer; a hit forwards the youngest buffered data so program order is preserved. This decouples store issue from memory-port contention and gives a drain/empty indication for pipeline fences.

## Interface
- DEPTH, 4, number of buffered stores; power of two, 2..16
- AW, 8, word-address bits compared and driven to memory (memory index = address[7:0])
- DW, 32, data width

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset); clears buffer immediately
- st_valid  in  1  pipeline presents a store this cycle
- st_addr  in  32  store address; only [AW-1:0] retained
- st_data  in  DW  store data
- st_ready  out  1  buffer can accept a store this cycle
- ld_valid  in  1  pipeline load this cycle (also blocks draining)
- ld_addr  in  32  load address; [AW-1:0] compared
- mem_rdata  in  DW  combinational read data from data memory
- ld_data  out  DW  load result: forwarded buffer data on hit, else mem_rdata
- ld_hit  out  1  load address matched a valid buffered entry
- MemWrite  out  1  write strobe to data memory
- ALUresult  out  32  write address to memory, zero-extended from AW bits
- WriteData  out  DW  write data to memory
- MemRead  out  1  equals ld_valid
- empty  out  1  no valid entries
- count  out  $clog2(DEPTH)+1  number of valid entries

## Operation
- Circular FIFO: wr_ptr, rd_ptr, count; entries hold {addr[AW-1:0], data}.
- Push: st_valid && st_ready at rising edge writes entry at wr_ptr, wr_ptr+1 mod DEPTH.
- st_ready = (count != DEPTH). No full-cycle bypass: when full, st_ready=0 even if a pop occurs that cycle.
- Drain: MemWrite = (count != 0) && !ld_valid; ALUresult/WriteData = head entry. Pop at same edge memory writes; rd_ptr+1 mod DEPTH.
- Loads have strict priority; a stream of loads stalls draining indefinitely (no starvation guard; fence by waiting for empty).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Forwarding: compare ld_addr[AW-1:0] with every valid entry; youngest matching entry (closest behind wr_ptr) supplies ld_data, ld_hit=1. A store pushed in the same cycle is NOT visible to a same-cycle load.
- ld_hit=0 and ld_data=mem_rdata when ld_valid=0 or no match.
- Outputs when empty: MemWrite=0, ALUresult=0, WriteData=0.

## Timing
- Reset (reset=0, asynchronous): count=0, pointers=0, st_ready=1, empty=1, MemWrite=0, ld_hit=0, ALUresult=0, WriteData=0. Reset mid-operation discards all buffered stores; no memory write issues in the reset cycle.
- Store-to-memory latency: store accepted at edge N is written to memory no earlier than edge N+1 (MemWrite high during cycle N..N+1 if it is head and ld_valid=0).
- Forwarding and MemWrite are combinational from registered state plus ld_valid/ld_addr; one cycle, no added load latency.
- Throughput: one push and one pop per cycle.
- Pointer wrap at DEPTH-1 -> 0; count distinguishes full/empty.

## Structure
- Shared package: DEPTH/AW/DW defaults, pointer width constant, entry struct {addr, data}.
- One sub-module: store_buffer_match, DEPTH-way address compare with youngest-first priority select returning hit and index; FIFO control stays in top.

## Test plan
- Reset then push (0x10, 0xAAAA0001) with ld_valid=0 -> next cycle MemWrite=1, ALUresult=0x10, WriteData=0xAAAA0001; following cycle empty=1.
- Hold ld_valid=1 (ld_addr 0x40), push 4 stores -> count=4, st_ready=0, MemWrite=0 throughout; 5th st_valid not accepted; drop ld_valid -> four writes in FIFO order on consecutive cycles.
- Push 0x20=0x1, 0x20=0x2 while loading; load 0x20 -> ld_hit=1, ld_data=0x2; load 0x21 -> ld_hit=0, ld_data=mem_rdata.
- Full buffer, push and pop same cycle -> push rejected (st_ready=0); next cycle count=3, st_ready=1; accepted push with pop keeps count constant.
- Pass DEPTH+3 stores through with interleaved loads -> pointers wrap, memory contents match program-order final values.
- Assert reset low mid-cycle with 3 entries -> immediately count=0, empty=1, MemWrite=0; no buffered store reaches memory.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared widths and entry layout for the MEM-stage
// posted-write store buffer.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 8;
  localparam int SB_DW    = 32;
  localparam int SB_PW    = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// Load-address compare across all buffered stores,
// picking the youngest match (closest behind wr_ptr).
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            vld_i,
  input  logic [DEPTH-1:0][SB_AW-1:0] addr_i,
  input  logic [SB_AW-1:0]            ld_addr_i,
  input  logic [PW-1:0]               wr_ptr_i,
  output logic                        hit_o,
  output logic [PW-1:0]               idx_o
);

  logic [PW-1:0] j;

  // Oldest-to-youngest scan; later hits override earlier.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    j     = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      j = wr_ptr_i - PW'(k);
      if (vld_i[j] && (addr_i[j] == ld_addr_i)) begin
        hit_o = 1'b1;
        idx_o = j;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO in front of data memory; drains
// when no load is issued and forwards youngest data.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [31:0]              st_addr,
  input  logic [SB_DW-1:0]         st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  input  logic [SB_DW-1:0]         mem_rdata,
  output logic [SB_DW-1:0]         ld_data,
  output logic                     ld_hit,
  output logic                     MemWrite,
  output logic [31:0]              ALUresult,
  output logic [SB_DW-1:0]         WriteData,
  output logic                     MemRead,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t     buf_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic push, pop;
  logic m_hit;
  logic [PW-1:0] m_idx;
  logic [PW-1:0] off;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0][SB_AW-1:0] addrs;
  sb_entry_t head;

  logic unused_hi;
  assign unused_hi = ^{st_addr[31:SB_AW], ld_addr[31:SB_AW]};

  assign head     = buf_q[rd_ptr_q];
  assign count    = cnt_q;
  assign empty    = (cnt_q == '0);
  assign st_ready = (cnt_q != CW'(DEPTH));
  assign MemRead  = ld_valid;
  assign MemWrite = !empty && !ld_valid;
  assign push     = st_valid && st_ready;
  assign pop      = MemWrite;

  assign ALUresult = empty ? 32'd0
                   : {{(32-SB_AW){1'b0}}, head.addr};
  assign WriteData = empty ? '0 : head.data;

  // Per-slot valid flags and address vector for the matcher.
  always_comb begin
    vld   = '0;
    addrs = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - rd_ptr_q;
      vld[i]   = (CW'(off) < cnt_q);
      addrs[i] = buf_q[i].addr;
    end
  end

  store_buffer_match #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_match (
    .vld_i     (vld),
    .addr_i    (addrs),
    .ld_addr_i (ld_addr[SB_AW-1:0]),
    .wr_ptr_i  (wr_ptr_q),
    .hit_o     (m_hit),
    .idx_o     (m_idx)
  );

  assign ld_hit  = ld_valid && m_hit;
  assign ld_data = ld_hit ? buf_q[m_idx].data : mem_rdata;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case (1'b1)
      push && !pop: cnt_d = cnt_q + CW'(1);
      !push && pop: cnt_d = cnt_q - CW'(1);
      default:      cnt_d = cnt_q;
    endcase
  end

  // FIFO state; reset discards all buffered stores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        buf_q[wr_ptr_q].addr <= st_addr[SB_AW-1:0];
        buf_q[wr_ptr_q].data <= st_data;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioral
// 256-word memory on the write port.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] mem_rdata;
  logic [31:0] ld_data;
  logic        ld_hit;
  logic        MemWrite;
  logic [31:0] ALUresult;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        empty;
  logic [2:0]  count;

  logic [31:0] mem [256];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .mem_rdata (mem_rdata),
    .ld_data   (ld_data),
    .ld_hit    (ld_hit),
    .MemWrite  (MemWrite),
    .ALUresult (ALUresult),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .empty     (empty),
    .count     (count)
  );

  assign mem_rdata = mem[ld_addr[7:0]];

  always @(posedge clk)
    if (MemWrite) mem[ALUresult[7:0]] <= WriteData;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    st_valid = 0;
    st_addr  = 0;
    st_data  = 0;
    ld_valid = 0;
    ld_addr  = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    #12;
    total++;
    if (count !== 3'd0 || empty !== 1'b1 || st_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state count=%0d empty=%b rdy=%b exp 0/1/1",
               count, empty, st_ready);
    end
    total++;
    if (MemWrite !== 1'b0 || ld_hit !== 1'b0 ||
        ALUresult !== 32'd0 || WriteData !== 32'd0) begin
      bad++;
      $display("FAIL reset_outs mw=%b hit=%b a=%h d=%h exp 0/0/0/0",
               MemWrite, ld_hit, ALUresult, WriteData);
    end
    @(negedge clk);
    reset = 1;
    tick();
  endtask

  task automatic test_single();
    st_valid = 1; st_addr = 32'h10; st_data = 32'hAAAA0001;
    #1;
    total++;
    if (MemWrite !== 1'b0) begin
      bad++;
      $display("FAIL single_nobypass MemWrite=%b exp 0", MemWrite);
    end
    tick();
    st_valid = 0;
    #1;
    total++;
    if (MemWrite !== 1'b1 || ALUresult !== 32'h10 ||
        WriteData !== 32'hAAAA0001) begin
      bad++;
      $display("FAIL single_write mw=%b a=%h d=%h exp 1/10/aaaa0001",
               MemWrite, ALUresult, WriteData);
    end
    tick();
    total++;
    if (empty !== 1'b1 || mem[8'h10] !== 32'hAAAA0001) begin
      bad++;
      $display("FAIL single_empty empty=%b mem=%h exp 1/aaaa0001",
               empty, mem[8'h10]);
    end
  endtask

  task automatic test_full();
    ld_valid = 1; ld_addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1; st_addr = 32'h50 + i; st_data = 32'h100 + i;
      #1;
      total++;
      if (MemWrite !== 1'b0) begin
        bad++;
        $display("FAIL full_stall%0d MemWrite=%b exp 0", i, MemWrite);
      end
      tick();
    end
    st_addr = 32'h54; st_data = 32'h104;
    #1;
    total++;
    if (count !== 3'd4 || st_ready !== 1'b0 || MemWrite !== 1'b0) begin
      bad++;
      $display("FAIL full_state count=%0d rdy=%b mw=%b exp 4/0/0",
               count, st_ready, MemWrite);
    end
    tick();
    total++;
    if (count !== 3'd4) begin
      bad++;
      $display("FAIL full_reject count=%0d exp 4", count);
    end
    st_valid = 0; ld_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (MemWrite !== 1'b1 || ALUresult !== 32'h50 + i ||
          WriteData !== 32'h100 + i) begin
        bad++;
        $display("FAIL full_drain%0d mw=%b a=%h d=%h exp 1/%h/%h",
                 i, MemWrite, ALUresult, WriteData, 32'h50 + i, 32'h100 + i);
      end
      tick();
    end
    total++;
    if (empty !== 1'b1 || mem[8'h54] !== 32'h0 || mem[8'h53] !== 32'h103) begin
      bad++;
      $display("FAIL full_after empty=%b m54=%h m53=%h exp 1/0/103",
               empty, mem[8'h54], mem[8'h53]);
    end
  endtask

  task automatic test_forward();
    ld_valid = 1; ld_addr = 32'h20;
    st_valid = 1; st_addr = 32'h20; st_data = 32'h1;
    #1;
    total++;
    if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin
      bad++;
      $display("FAIL fwd_samecycle hit=%b data=%h exp 0/0", ld_hit, ld_data);
    end
    tick();
    st_data = 32'h2;
    tick();
    st_valid = 0;
    #1;
    total++;
    if (ld_hit !== 1'b1 || ld_data !== 32'h2) begin
      bad++;
      $display("FAIL fwd_young hit=%b data=%h exp 1/2", ld_hit, ld_data);
    end
    ld_addr = 32'h21;
    #1;
    total++;
    if (ld_hit !== 1'b0 || ld_data !== 32'hDEAD0021) begin
      bad++;
      $display("FAIL fwd_miss hit=%b data=%h exp 0/dead0021", ld_hit, ld_data);
    end
    ld_addr = 32'h120;
    #1;
    total++;
    if (ld_hit !== 1'b1 || ld_data !== 32'h2) begin
      bad++;
      $display("FAIL fwd_hibits hit=%b data=%h exp 1/2", ld_hit, ld_data);
    end
    ld_valid = 0;
    #1;
    total++;
    if (ld_hit !== 1'b0 || MemRead !== 1'b0) begin
      bad++;
      $display("FAIL fwd_noload hit=%b rd=%b exp 0/0", ld_hit, MemRead);
    end
    tick();
    tick();
    total++;
    if (empty !== 1'b1 || mem[8'h20] !== 32'h2) begin
      bad++;
      $display("FAIL fwd_order empty=%b m20=%h exp 1/2", empty, mem[8'h20]);
    end
  endtask

  task automatic test_full_pushpop();
    ld_valid = 1; ld_addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1; st_addr = 32'h60 + i; st_data = 32'h200 + i;
      tick();
    end
    ld_valid = 0;
    st_addr = 32'h64; st_data = 32'h204;
    #1;
    total++;
    if (st_ready !== 1'b0 || MemWrite !== 1'b1) begin
      bad++;
      $display("FAIL pp_full rdy=%b mw=%b exp 0/1", st_ready, MemWrite);
    end
    tick();
    total++;
    if (count !== 3'd3 || st_ready !== 1'b1) begin
      bad++;
      $display("FAIL pp_after count=%0d rdy=%b exp 3/1", count, st_ready);
    end
    tick();
    total++;
    if (count !== 3'd3) begin
      bad++;
      $display("FAIL pp_steady count=%0d exp 3", count);
    end
    st_valid = 0;
    tick(); tick(); tick();
    total++;
    if (empty !== 1'b1 || mem[8'h64] !== 32'h204 || mem[8'h60] !== 32'h200) begin
      bad++;
      $display("FAIL pp_mem empty=%b m64=%h m60=%h exp 1/204/200",
               empty, mem[8'h64], mem[8'h60]);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 7; i++) begin
      st_valid = 1;
      st_addr  = 32'h70 + (i % 3);
      st_data  = 32'h300 + i;
      ld_valid = (i % 2 == 0);
      ld_addr  = 32'h90;
      #1;
      total++;
      if (st_ready !== 1'b1) begin
        bad++;
        $display("FAIL wrap_rdy%0d rdy=%b exp 1", i, st_ready);
      end
      tick();
    end
    st_valid = 0;
    ld_valid = 1; ld_addr = 32'h70;
    #1;
    total++;
    if (count !== 3'd4 || ld_hit !== 1'b1 || ld_data !== 32'h306) begin
      bad++;
      $display("FAIL wrap_fwd count=%0d hit=%b data=%h exp 4/1/306",
               count, ld_hit, ld_data);
    end
    ld_valid = 0;
    tick(); tick(); tick(); tick();
    total++;
    if (empty !== 1'b1 || mem[8'h70] !== 32'h306 ||
        mem[8'h71] !== 32'h304 || mem[8'h72] !== 32'h305) begin
      bad++;
      $display("FAIL wrap_mem e=%b m70=%h m71=%h m72=%h exp 1/306/304/305",
               empty, mem[8'h70], mem[8'h71], mem[8'h72]);
    end
  endtask

  task automatic test_reset_mid();
    ld_valid = 1; ld_addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1; st_addr = 32'h80 + i; st_data = 32'h400 + i;
      tick();
    end
    st_valid = 0;
    #2;
    ld_valid = 0;
    reset    = 0;
    #1;
    total++;
    if (count !== 3'd0 || empty !== 1'b1 || MemWrite !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid count=%0d empty=%b mw=%b exp 0/1/0",
               count, empty, MemWrite);
    end
    tick();
    @(negedge clk);
    reset = 1;
    tick(); tick(); tick();
    total++;
    if (mem[8'h80] !== 32'h0 || mem[8'h81] !== 32'h0 ||
        mem[8'h82] !== 32'h0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL rst_discard m80=%h m81=%h m82=%h e=%b exp 0/0/0/1",
               mem[8'h80], mem[8'h81], mem[8'h82], empty);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h21] = 32'hDEAD0021;
    test_reset();
    test_single();
    test_full();
    test_forward();
    test_full_pushpop();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
